sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester controller for a single-port, byte-masked, synchronous-read SRAM macro (the 1024x128 RW0-style data-array macros with 1-cycle read latency). Clears the array after reset, then shares the single port between requesters A and B with round-robin arbitration. Returns read data to the issuing requester one cycle after acceptance. Sits between cache/refill logic and the `*_ext` SRAM macro.

## Interface
- `ADDR_W`, 10, SRAM address width; depth = 2^ADDR_W
- `DATA_W`, 128, data width
- `MASK_W`, 16, write-mask width; each mask bit covers DATA_W/MASK_W bits
- `INIT_ON_RESET`, 1, 1 = zero-fill the whole array after reset; 0 = skip init

- `clock`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `a_req_valid`  in  1  requester A has a request
- `a_req_ready`  out  1  A's request accepted this cycle when high with valid
- `a_req_write`  in  1  1 = write, 0 = read
- `a_req_addr`  in  ADDR_W  word address
- `a_req_wmask`  in  MASK_W  write byte-lane mask
- `a_req_wdata`  in  DATA_W  write data
- `b_req_*`  same set of ports and widths as A, for requester B
- `a_resp_valid`  out  1  read data for A on `resp_rdata` this cycle
- `b_resp_valid`  out  1  read data for B on `resp_rdata` this cycle
- `resp_rdata`  out  DATA_W  shared read-data return; direct from `sram_rdata`
- `init_done`  out  1  high once the array is cleared and arbitration is live
- `sram_en`, `sram_wmode`, `sram_addr` (ADDR_W), `sram_wmask` (MASK_W), `sram_wdata` (DATA_W)  out  drive macro RW0_en/wmode/addr/wmask/wdata
- `sram_rdata`  in  DATA_W  macro RW0_rdata

## Operation
- States: INIT, RUN. `reset` low forces INIT, init counter = 0, round-robin pointer = A, response flags = 0, `init_done` = 0.
- INIT with INIT_ON_RESET=1:
  - Every cycle drives `sram_en`=1, `sram_wmode`=1, `sram_addr`=counter, `sram_wmask`=all ones, `sram_wdata`=0.
  - Counter increments each cycle.
  - When counter = 2^ADDR_W-1, next state is RUN and `init_done` is set.
  - Both `*_req_ready` = 0 throughout INIT.
- INIT with INIT_ON_RESET=0: no SRAM activity; RUN on the first edge after reset release.
- RUN arbitration:
  - Grant is combinational.
  - Only one valid: that requester gets `ready`=1.
  - Both valid: the requester named by the round-robin pointer wins.
  - The pointer flips to the non-winner only on an accepted grant; with no grant it holds.
- Accepted request, same cycle:
  - `sram_en`=1; `sram_wmode`=write bit.
  - addr/wmask/wdata come from the winner.
  - On reads, `sram_wmask`/`sram_wdata` are driven to 0.
- No accepted request: `sram_en`=0; other SRAM outputs = 0.
- An accepted read sets the winner's `*_resp_valid` for exactly the next cycle. Writes produce no response.
- `ready` may depend combinationally on `valid`. `valid` must not depend on `ready`. A requester holds its request stable until accepted.

## Timing
- Reset values: all `*_req_ready`, `*_resp_valid`, `init_done`, `sram_en`, `sram_wmode` = 0; `sram_addr`/`sram_wmask`/`sram_wdata` = 0.
  - Exception: with INIT_ON_RESET=1, while `reset` is low the SRAM outputs are the INIT drive values with counter = 0.
- Init length (INIT_ON_RESET=1):
  - Init writes occupy cycles 0..2^ADDR_W-1 after reset release.
  - `init_done` and first possible grant occur at cycle 2^ADDR_W (cycle 1024 at default).
- Read latency: request accepted at edge N → `*_resp_valid`=1 and valid `resp_rdata` during cycle N+1. Throughput is one access per cycle.
- Back-to-back: a write accepted at N followed by a read of the same address accepted at N+1 returns the new data at N+2.
- A and B responses are never valid in the same cycle.
- Reset asserted mid-operation:
  - All flags clear immediately (asynchronous); a pending response is dropped.
  - After release, INIT restarts from address 0.
- Counter at the last address: no wrap back into INIT; RUN is terminal until reset.

## Test plan
- Reset release, INIT_ON_RESET=1, ADDR_W=10 → exactly 1024 writes (addr 0..1023, mask 0xFFFF, data 0); `init_done` rises at cycle 1024; no `ready` before it.
- After init, A reads addr 0x005 → `a_resp_valid` one cycle later with `resp_rdata`=0.
- A writes 0xDEADBEEF... to addr 0x3FF with mask 0x000F; next cycle B reads 0x3FF → `b_resp_valid` next cycle; low 4 bytes = written data, remaining bytes = 0.
- A and B both valid continuously for 6 cycles → grants alternate A,B,A,B,A,B; responses alternate with 1-cycle latency; never both in one cycle.
- Only B valid for 3 cycles, then both valid → B wins 3 times, then A wins (pointer flipped to A after B's last grant).
- Reset pulsed low the cycle after A's read is accepted → `a_resp_valid` stays 0; INIT restarts at addr 0; `init_done` low until cycle 1024 after release.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin front end for a 1-cycle-latency single-port SRAM.
// Zero-fills the array after reset, then arbitrates A/B onto the macro port.
module sram_port_arbiter #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 128,
  parameter int MASK_W        = 16,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_write,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [MASK_W-1:0] a_req_wmask,
  input  logic [DATA_W-1:0] a_req_wdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_write,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [MASK_W-1:0] b_req_wmask,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              a_resp_valid,
  output logic              b_resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              a_rv_q, a_rv_d;
  logic              b_rv_q, b_rv_d;
  logic              a_win, b_win;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      a_rv_q  <= a_rv_d;
      b_rv_q  <= b_rv_d;
    end
  end

  // rr_q: 0 favours A, 1 favours B when both are valid
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    a_win       = 1'b0;
    b_win       = 1'b0;
    sram_en     = 1'b0;
    sram_wmode  = 1'b0;
    sram_addr   = '0;
    sram_wmask  = '0;
    sram_wdata  = '0;
    unique case (state_q)
      INIT: begin
        if (INIT_ON_RESET != 0) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = cnt_q;
          sram_wmask = '1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = RUN;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        a_win = a_req_valid & (~b_req_valid | ~rr_q);
        b_win = b_req_valid & (~a_req_valid | rr_q);
        if (a_win) begin
          rr_d       = 1'b1;
          sram_en    = 1'b1;
          sram_wmode = a_req_write;
          sram_addr  = a_req_addr;
          if (a_req_write) begin
            sram_wmask = a_req_wmask;
            sram_wdata = a_req_wdata;
          end
        end else if (b_win) begin
          rr_d       = 1'b0;
          sram_en    = 1'b1;
          sram_wmode = b_req_write;
          sram_addr  = b_req_addr;
          if (b_req_write) begin
            sram_wmask = b_req_wmask;
            sram_wdata = b_req_wdata;
          end
        end
      end
      default: state_d = INIT;
    endcase
    a_rv_d = a_win & ~a_req_write;
    b_rv_d = b_win & ~b_req_write;
  end

  assign a_req_ready  = a_win;
  assign b_req_ready  = b_win;
  assign a_resp_valid = a_rv_q;
  assign b_resp_valid = b_rv_q;
  assign resp_rdata   = sram_rdata;
  assign init_done    = (state_q == RUN);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural 1024x128 SRAM.
// Directed stimulus pushes expected read returns; a monitor pops and checks.
module tb_sram_port_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         a_req_valid = 1'b0, a_req_write = 1'b0;
  logic [9:0]   a_req_addr = '0;
  logic [15:0]  a_req_wmask = '0;
  logic [127:0] a_req_wdata = '0;
  logic         b_req_valid = 1'b0, b_req_write = 1'b0;
  logic [9:0]   b_req_addr = '0;
  logic [15:0]  b_req_wmask = '0;
  logic [127:0] b_req_wdata = '0;
  logic         a_req_ready, b_req_ready;
  logic         a_resp_valid, b_resp_valid, init_done;
  logic [127:0] resp_rdata;
  logic         sram_en, sram_wmode;
  logic [9:0]   sram_addr;
  logic [15:0]  sram_wmask;
  logic [127:0] sram_wdata;
  logic [127:0] sram_rdata;

  sram_port_arbiter dut (
    .clock(clock), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_req_write(a_req_write), .a_req_addr(a_req_addr),
    .a_req_wmask(a_req_wmask), .a_req_wdata(a_req_wdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_req_write(b_req_write), .b_req_addr(b_req_addr),
    .b_req_wmask(b_req_wmask), .b_req_wdata(b_req_wdata),
    .a_resp_valid(a_resp_valid), .b_resp_valid(b_resp_valid),
    .resp_rdata(resp_rdata), .init_done(init_done),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  logic [127:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {4{32'hA5A5_5A5A}};
    sram_rdata = '0;
  end
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int k = 0; k < 16; k++)
          if (sram_wmask[k]) mem[sram_addr][k*8 +: 8] <= sram_wdata[k*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit           who;
    logic [127:0] data;
    int           due;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] ZERO = 128'h0;
  localparam logic [127:0] PAT  = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] PATL = {96'h0, 32'hDEAD_BEEF};

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (a_resp_valid && b_resp_valid)
        check("resp_both", 1, 0);
      if (a_resp_valid || b_resp_valid) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_who", {127'h0, b_resp_valid}, {127'h0, e.who});
          check("resp_cycle", 128'(cyc), 128'(e.due));
          check("resp_data", resp_rdata, e.data);
        end
      end else if (sb.size() != 0 && sb[0].due < cyc) begin
        check("resp_missing", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic init_seq(input bit poke_b);
    int bad;
    bad = 0;
    b_req_valid = poke_b;
    b_req_write = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clock);
      if (!(sram_en && sram_wmode && sram_addr == 10'(k) &&
            sram_wmask == 16'hFFFF && sram_wdata == ZERO &&
            !a_req_ready && !b_req_ready && !init_done))
        bad++;
    end
    b_req_valid = 1'b0;
    b_req_write = 1'b0;
    check("init_sweep_bad", 128'(bad), 0);
    @(negedge clock);
    check("init_done_1024", {127'h0, init_done}, 1);
    check("idle_en", {127'h0, sram_en}, 0);
    @(posedge clock); #1;
  endtask

  task automatic req(input bit who, input bit wr, input logic [9:0] addr,
                     input logic [15:0] mask, input logic [127:0] data,
                     input logic [127:0] exp);
    bit got;
    got = 0;
    if (!who) begin
      a_req_valid = 1; a_req_write = wr; a_req_addr = addr;
      a_req_wmask = mask; a_req_wdata = data;
    end else begin
      b_req_valid = 1; b_req_write = wr; b_req_addr = addr;
      b_req_wmask = mask; b_req_wdata = data;
    end
    for (int t = 0; t < 8 && !got; t++) begin
      @(negedge clock);
      got = who ? b_req_ready : a_req_ready;
      if (got && !wr) sb.push_back('{who, exp, cyc + 1});
      @(posedge clock); #1;
    end
    check("req_accept", {127'h0, got}, 1);
    if (!who) a_req_valid = 0; else b_req_valid = 0;
  endtask

  task automatic grant(input string name, input bit who,
                       input logic [127:0] exp);
    @(negedge clock);
    check(name, {126'h0, b_req_ready, a_req_ready}, who ? 2 : 1);
    if (a_req_ready || b_req_ready)
      sb.push_back('{b_req_ready, exp, cyc + 1});
    @(posedge clock); #1;
  endtask

  initial begin
    #2;
    check("rst_ready", {126'h0, a_req_ready, b_req_ready}, 0);
    check("rst_flags", {125'h0, a_resp_valid, b_resp_valid, init_done}, 0);
    check("rst_sram", {sram_en, sram_wmode, sram_addr, sram_wmask},
          {2'b11, 10'h0, 16'hFFFF});
    @(posedge clock); #1;
    reset = 1;
    init_seq(1);

    req(0, 0, 10'h005, 16'h0, ZERO, ZERO);
    req(0, 1, 10'h3FF, 16'h000F, PAT, ZERO);
    req(1, 0, 10'h3FF, 16'h0, ZERO, PATL);

    a_req_valid = 1; a_req_write = 0; a_req_addr = 10'h3FF;
    b_req_valid = 1; b_req_write = 0; b_req_addr = 10'h005;
    for (int i = 0; i < 6; i++)
      grant("alt_grant", i[0], i[0] ? ZERO : PATL);
    a_req_valid = 0;
    for (int i = 0; i < 3; i++) grant("b_only", 1, ZERO);
    a_req_valid = 1;
    grant("rr_after_b", 0, PATL);
    grant("rr_then_b", 1, ZERO);
    a_req_valid = 0; b_req_valid = 0;
    repeat (3) @(posedge clock);
    #1;
    check("sb_drained", 128'(sb.size()), 0);

    a_req_valid = 1; a_req_write = 0; a_req_addr = 10'h005;
    @(negedge clock);
    check("pre_rst_ready", {127'h0, a_req_ready}, 1);
    @(posedge clock); #1;
    a_req_valid = 0;
    reset = 0;
    @(negedge clock);
    check("rst_drop_resp", {127'h0, a_resp_valid}, 0);
    check("rst_init_drive", {sram_en, sram_addr, init_done}, {1'b1, 10'h0, 1'b0});
    @(posedge clock); #1;
    reset = 1;
    init_seq(0);
    req(1, 0, 10'h3FF, 16'h0, ZERO, ZERO);
    repeat (2) @(posedge clock);
    #1;
    check("sb_final", 128'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
